// File: rtl/exec_pkg.sv
// Shared definitions for the exec_ctrl slice: opcodes, FSM encoding,
// instruction field positions and a small decode helper.
package exec_pkg;

    localparam int NUM_REGS   = 4;
    localparam int REG_ADDR_W = 2;
    localparam int INSTR_W    = 8;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int DST_MSB  = 5;
    localparam int DST_LSB  = 4;
    localparam int SRC1_MSB = 3;
    localparam int SRC1_LSB = 2;
    localparam int SRC2_MSB = 1;
    localparam int SRC2_LSB = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]            op;
        logic [REG_ADDR_W-1:0] dst;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op   = raw[OP_MSB:OP_LSB];
        d.dst  = raw[DST_MSB:DST_LSB];
        d.src1 = raw[SRC1_MSB:SRC1_LSB];
        d.src2 = raw[SRC2_MSB:SRC2_LSB];
        return d;
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// 4-entry register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module exec_regfile
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0]     rd_data_a_o,
    input  logic [REG_ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0]     rd_data_b_o,
    input  logic [REG_ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]     dbg_data_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];
    assign dbg_data_o  = mem_q[dbg_addr_i];

endmodule

// File: rtl/exec_ctrl.sv
// Three-state issue controller: captures an instruction and its operands,
// drives an external 1-cycle execute unit and retires the result.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    input  logic                  load_en,
    input  logic [REG_ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [1:0]            alu_op,
    output logic [DATA_W-1:0]     alu_src1,
    output logic [DATA_W-1:0]     alu_src2,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  done,
    output logic                  div0,
    output logic                  busy,
    output logic [7:0]            retired
);

    state_t state_q, state_d;

    logic [1:0]            op_q;
    logic [REG_ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0]     src1_q;
    logic [DATA_W-1:0]     src2_q;
    logic                  done_q;
    logic                  div0_q;
    logic [7:0]            retired_q;

    instr_t                dec;
    logic                  handshake;
    logic                  loadAccept;
    logic                  retire;
    logic                  div0Hit;
    logic [DATA_W-1:0]     rdDataA;
    logic [DATA_W-1:0]     rdDataB;
    logic                  wrEn;
    logic [REG_ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0]     wrData;

    assign dec         = decode_instr(instr);
    assign instr_ready = (state_q == ST_IDLE) && !load_en;
    assign handshake   = instr_valid && instr_ready;
    assign loadAccept  = (state_q == ST_IDLE) && load_en;
    assign retire      = (state_q == ST_WAIT);
    assign div0Hit     = (op_q == OP_DIV) && (src2_q == '0);

    // Loads only happen in IDLE and retirement only in WAIT, so one port suffices.
    assign wrEn   = loadAccept || retire;
    assign wrAddr = retire ? dst_q : load_addr;
    assign wrData = retire ? (div0Hit ? '0 : alu_result) : load_data;

    exec_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (wrEn),
        .wr_addr_i   (wrAddr),
        .wr_data_i   (wrData),
        .rd_addr_a_i (dec.src1),
        .rd_data_a_o (rdDataA),
        .rd_addr_b_i (dec.src2),
        .rd_data_b_o (rdDataB),
        .dbg_addr_i  (dbg_addr),
        .dbg_data_o  (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (handshake) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand registers double as the execute-unit drive and keep the last
    // issued values while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= retire;
            div0_q  <= retire && div0Hit;
            if (handshake) begin
                op_q   <= dec.op;
                dst_q  <= dec.dst;
                src1_q <= rdDataA;
                src2_q <= rdDataB;
            end
            if (retire) begin
                retired_q <= retired_q + 8'd1;
            end
        end
    end

    assign alu_op   = op_q;
    assign alu_src1 = src1_q;
    assign alu_src2 = src2_q;
    assign done     = done_q;
    assign div0     = div0_q;
    assign busy     = (state_q != ST_IDLE);
    assign retired  = retired_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl with a behavioural execute unit and an
// arithmetic reference model of the register file.
module tb_exec_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         instrValid;
    logic [7:0]   instr;
    logic         instrReady;
    logic         loadEn;
    logic [1:0]   loadAddr;
    logic [W-1:0] loadData;
    logic [1:0]   dbgAddr;
    logic [W-1:0] dbgData;
    logic [1:0]   aluOp;
    logic [W-1:0] aluSrc1;
    logic [W-1:0] aluSrc2;
    logic [W-1:0] aluResult;
    logic         done;
    logic         div0;
    logic         busy;
    logic [7:0]   retired;

    typedef struct {
        int dst;
        int value;
        bit divz;
        int hsCyc;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    int   model[4];
    int   expRetired;
    int   nChecks;
    int   nFails;
    int   cyc;
    logic [1:0] reqAddr;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    exec_ctrl #(.DATA_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instrValid),
        .instr       (instr),
        .instr_ready (instrReady),
        .load_en     (loadEn),
        .load_addr   (loadAddr),
        .load_data   (loadData),
        .dbg_addr    (dbgAddr),
        .dbg_data    (dbgData),
        .alu_op      (aluOp),
        .alu_src1    (aluSrc1),
        .alu_src2    (aluSrc2),
        .alu_result  (aluResult),
        .done        (done),
        .div0        (div0),
        .busy        (busy),
        .retired     (retired)
    );

    // External execute unit; divide by zero returns all-ones so the
    // controller's override is observable.
    always @(posedge clk) begin
        case (aluOp)
            2'b00:   aluResult <= aluSrc1 + aluSrc2;
            2'b01:   aluResult <= aluSrc1 - aluSrc2;
            2'b10:   aluResult <= aluSrc1 * aluSrc2;
            default: aluResult <= (aluSrc2 == '0) ? '1 : aluSrc1 / aluSrc2;
        endcase
    end

    function automatic void predict(input int op, input int a, input int b,
                                    output int v, output bit dz);
        dz = 1'b0;
        case (op)
            0: v = (a + b) % 256;
            1: v = (a - b + 256) % 256;
            2: v = (a * b) % 256;
            default: begin
                if (b == 0) begin
                    v  = 0;
                    dz = 1'b1;
                end else begin
                    v = a / b;
                end
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 50; i++) begin
            if (!busy && sb.size() == 0) return;
            @(negedge clk);
            #1;
        end
        checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic checkReg(input int a, input int exp);
        reqAddr = 2'(a);
        @(negedge clk);
        #2;
        checkOutput($sformatf("reg_r%0d", a), int'(dbgData), exp);
    endtask

    task automatic loadReg(input int a, input int d);
        waitIdle();
        tick();
        loadEn   = 1'b1;
        loadAddr = 2'(a);
        loadData = W'(d);
        tick();
        loadEn   = 1'b0;
        model[a] = d;
    endtask

    // Offers one instruction; on acceptance the expected retirement is queued.
    task automatic applyStimulus(input logic [7:0] ins, input bit keepValid,
                                 input bit sync, output int hs);
        int   op, d, s1, s2, v;
        bit   dz;
        exp_t ent;
        if (sync) tick();
        instr      = ins;
        instrValid = 1'b1;
        op = int'(ins[7:6]);
        d  = int'(ins[5:4]);
        s1 = int'(ins[3:2]);
        s2 = int'(ins[1:0]);
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instrReady) begin
                hs = cyc;
                predict(op, model[s1], model[s2], v, dz);
                model[d]  = v;
                ent.dst   = d;
                ent.value = v;
                ent.divz  = dz;
                ent.hsCyc = cyc;
                sb.push_back(ent);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (hs < 0) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keepValid) instrValid = 1'b0;
    endtask

    // Monitor: every done pulse is matched against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                    dbgAddr = reqAddr;
                end else begin
                    monE    = sb.pop_front();
                    dbgAddr = 2'(monE.dst);
                    #1;
                    checkOutput("result", int'(dbgData), monE.value);
                    checkOutput("div0_flag", int'(div0), int'(monE.divz));
                    checkOutput("done_latency", cyc, monE.hsCyc + 3);
                    expRetired = (expRetired + 1) % 256;
                    checkOutput("retired_count", int'(retired), expRetired);
                end
            end else begin
                dbgAddr = reqAddr;
                if (div0) checkOutput("div0_without_done", 1, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hs, prevHs, ldCyc;
        logic [7:0] ins;
        nChecks    = 0;
        nFails     = 0;
        cyc        = 0;
        expRetired = 0;
        reqAddr    = '0;
        dbgAddr    = '0;
        reset      = 1'b1;
        instrValid = 1'b0;
        instr      = '0;
        loadEn     = 1'b0;
        loadAddr   = '0;
        loadData   = '0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        repeat (3) tick();
        reset = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_div0", int'(div0), 0);
        checkOutput("rst_retired", int'(retired), 0);
        checkOutput("rst_ready", int'(instrReady), 1);
        checkOutput("rst_alu_op", int'(aluOp), 0);
        checkOutput("rst_alu_src1", int'(aluSrc1), 0);
        checkOutput("rst_alu_src2", int'(aluSrc2), 0);
        for (int i = 0; i < 4; i++) checkReg(i, 0);

        $display("[TB] add");
        loadReg(1, 5);
        loadReg(2, 3);
        applyStimulus(8'b00_00_01_10, 1'b0, 1'b1, hs);
        waitIdle();
        checkReg(0, 8);
        checkOutput("retired_after_add", int'(retired), 1);

        $display("[TB] sub and mul wrap");
        loadReg(1, 200);
        loadReg(2, 100);
        applyStimulus(8'b01_11_10_01, 1'b0, 1'b1, hs);
        waitIdle();
        checkReg(3, 8'h9C);
        applyStimulus(8'b10_00_01_10, 1'b0, 1'b1, hs);
        waitIdle();
        checkReg(0, 8'h20);

        $display("[TB] divide");
        loadReg(1, 7);
        loadReg(2, 0);
        applyStimulus(8'b11_11_01_10, 1'b0, 1'b1, hs);
        waitIdle();
        checkReg(3, 0);
        applyStimulus(8'b11_11_01_01, 1'b0, 1'b1, hs);
        waitIdle();
        checkReg(3, 1);
        applyStimulus(8'b00_01_01_01, 1'b0, 1'b1, hs);
        waitIdle();
        checkReg(1, 14);

        $display("[TB] back-to-back");
        prevHs = 0;
        for (int i = 0; i < 6; i++) begin
            ins = 8'($urandom);
            applyStimulus(ins, (i < 5), 1'b1, hs);
            if (i > 0) checkOutput("throughput", hs - prevHs, 3);
            prevHs = hs;
        end
        waitIdle();

        $display("[TB] load priority");
        tick();
        instr      = 8'b00_10_01_00;
        instrValid = 1'b1;
        loadEn     = 1'b1;
        loadAddr   = 2'd0;
        loadData   = 8'd9;
        @(negedge clk);
        checkOutput("ready_low_on_load", int'(instrReady), 0);
        ldCyc = cyc;
        @(posedge clk);
        #1;
        loadEn   = 1'b0;
        model[0] = 9;
        applyStimulus(8'b00_10_01_00, 1'b0, 1'b0, hs);
        checkOutput("accept_after_load", hs, ldCyc + 1);
        waitIdle();
        checkReg(0, 9);

        $display("[TB] load ignored while busy");
        loadReg(3, 8'h11);
        applyStimulus(8'b00_00_01_01, 1'b0, 1'b1, hs);
        loadEn   = 1'b1;
        loadAddr = 2'd3;
        loadData = 8'hAA;
        tick();
        loadEn   = 1'b0;
        waitIdle();
        checkReg(3, 8'h11);

        $display("[TB] reset during wait");
        loadReg(1, 11);
        loadReg(2, 22);
        applyStimulus(8'b00_00_01_10, 1'b0, 1'b1, hs);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) model[i] = 0;
        expRetired = 0;
        @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_retired", int'(retired), 0);
        checkOutput("abort_done", int'(done), 0);
        repeat (5) tick();
        checkReg(0, 0);
        checkReg(1, 0);

        $display("[TB] random traffic and retired wrap");
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                loadReg($urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
            end
            ins = 8'($urandom);
            applyStimulus(ins, 1'b0, 1'b1, hs);
        end
        waitIdle();
        checkOutput("retired_wrap", int'(retired), 0);
        for (int i = 0; i < 20; i++) begin
            ins = 8'($urandom);
            applyStimulus(ins, 1'b0, 1'b1, hs);
        end
        waitIdle();
        for (int i = 0; i < 4; i++) checkReg(i, model[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
